// File: rtl/viterbi_traceback.sv
// Survivor memory and traceback for the Viterbi decoder.
// Decision columns go into a circular buffer of TB_LEN columns. Once the
// buffer is full, each accepted column first traces back from the ACS best
// state to decode the oldest column, and then overwrites that column. At end
// of frame the remaining columns are drained by tracing back from state 0,
// which assumes a zero-tailed trellis.

// One traceback step: move from the state at one column to its predecessor
// at the next older column, or pass the state through when inactive.
module viterbi_traceback_step #(
    parameter  int NUM_STATE = 4,
    localparam int M         = $clog2(NUM_STATE)
) (
    input  logic [NUM_STATE-1:0] dec,
    input  logic [M-1:0]         s_in,
    input  logic                 act,
    output logic [M-1:0]         s_out
);

    logic d;

    assign d = dec[s_in];

    // The predecessor shifts the state left and brings the decision in as the LSB.
    if (M == 1) begin : g_m1
        assign s_out = act ? d : s_in;
    end else begin : g_mn
        assign s_out = act ? {s_in[M-2:0], d} : s_in;
    end

endmodule

module viterbi_traceback #(
    parameter  int NUM_STATE = 4,
    parameter  int TB_LEN    = 16,
    localparam int M         = $clog2(NUM_STATE),
    localparam int PW        = $clog2(TB_LEN),
    localparam int FW        = $clog2(TB_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 i_en_m,
    input  logic                 i_en_t,
    input  logic [NUM_STATE-1:0] i_dec,
    input  logic [M-1:0]         i_best_state,
    input  logic                 i_last,
    output logic                 o_bit,
    output logic                 o_valid,
    output logic                 o_done
);

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [TB_LEN-1:0][NUM_STATE-1:0] mem;
    logic [PW-1:0]                    wr_ptr, rd_ptr;
    logic [FW-1:0]                    fill;

    logic wr_en, emit, rd_adv, fill_inc, fill_dec, flush_s0;
    logic tb_bit;

    // Traceback state per column, index 0 being the newest column.
    logic [M-1:0] tb_st [TB_LEN];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(TB_LEN - 1)) ? '0 : p + 1'b1;
    endfunction

    // Column index n positions behind p, modulo TB_LEN (0 <= n <= TB_LEN).
    function automatic logic [PW-1:0] ptr_back(input logic [PW-1:0] p, input int n);
        int v;
        v = int'(p) - n;
        if (v < 0) v = v + TB_LEN;
        return PW'(v);
    endfunction

    // State register; everything freezes while en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    state_q <= S_FILL;
        else if (en) state_q <= state_d;
    end

    // Next state and datapath controls.
    always_comb begin
        state_d  = state_q;
        wr_en    = 1'b0;
        emit     = 1'b0;
        rd_adv   = 1'b0;
        fill_inc = 1'b0;
        fill_dec = 1'b0;
        flush_s0 = 1'b0;
        case (state_q)
            S_FILL: begin
                if (i_en_m) begin
                    wr_en    = 1'b1;
                    fill_inc = 1'b1;
                end
                if (i_last)
                    state_d = S_FLUSH;
                else if (i_en_m && fill == FW'(TB_LEN - 1))
                    state_d = S_RUN;
            end
            S_RUN: begin
                // Without traceback permission the column is not taken;
                // upstream holds it, so nothing is lost.
                if (i_en_m && i_en_t) begin
                    wr_en  = 1'b1;
                    emit   = 1'b1;
                    rd_adv = 1'b1;
                end
                if (i_last) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (fill != '0) begin
                    emit     = 1'b1;
                    rd_adv   = 1'b1;
                    fill_dec = 1'b1;
                    flush_s0 = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: ;
        endcase
    end

    // Survivor buffer; contents need no reset.
    always_ff @(posedge clk) begin
        if (en && wr_en) mem[wr_ptr] <= i_dec;
    end

    // Traceback chain over the stored columns, newest first. Step k moves
    // from column newest-k to newest-k-1 and is active only while it stays
    // within the fill, so the chain always ends on the oldest column.
    assign tb_st[0] = flush_s0 ? '0 : i_best_state;

    for (genvar k = 0; k < TB_LEN - 1; k++) begin : g_step
        logic [PW-1:0] col;
        logic          act;

        assign col = ptr_back(wr_ptr, k + 1);
        assign act = (fill > FW'(k + 1));

        viterbi_traceback_step #(
            .NUM_STATE (NUM_STATE)
        ) u_step (
            .dec   (mem[col]),
            .s_in  (tb_st[k]),
            .act   (act),
            .s_out (tb_st[k+1])
        );
    end

    // The decoded bit is the input that led into the oldest column's state.
    assign tb_bit = tb_st[TB_LEN-1][M-1];

    // Pointers, fill level and registered output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill    <= '0;
            o_bit   <= 1'b0;
            o_valid <= 1'b0;
        end else if (en) begin
            if (wr_en)  wr_ptr <= ptr_inc(wr_ptr);
            if (rd_adv) rd_ptr <= ptr_inc(rd_ptr);
            if (fill_inc && fill != FW'(TB_LEN))
                fill <= fill + 1'b1;
            else if (fill_dec)
                fill <= fill - 1'b1;
            o_valid <= emit;
            o_bit   <= emit & tb_bit;
        end
    end

    assign o_done = (state_q == S_DONE);

    // The read pointer always sits fill columns behind the write pointer.
    a_ptr_fill : assert property (@(posedge clk) disable iff (!rst)
        rd_ptr == ptr_back(wr_ptr, int'(fill)));

endmodule

// File: tb/tb_viterbi_traceback.sv
// Scoreboard bench for viterbi_traceback: frames are built from a noiseless
// trellis model (input bits -> state path -> decision columns with random
// off-path decisions), and each decoded bit must reproduce the input stream.
module tb_viterbi_traceback;

    localparam int NS  = 4;
    localparam int TBL = 16;
    localparam int M   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b1;
    logic          i_en_m = 1'b0;
    logic          i_en_t = 1'b0;
    logic [NS-1:0] i_dec = '0;
    logic [M-1:0]  i_best_state = '0;
    logic          i_last = 1'b0;
    logic          o_bit, o_valid, o_done;

    int n_run  = 0;
    int n_fail = 0;
    int n_emit = 0;
    bit q[$];
    bit mon_exp;
    logic en_last = 1'b0;
    bit gold[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    viterbi_traceback #(
        .NUM_STATE (NS),
        .TB_LEN    (TBL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .i_en_m       (i_en_m),
        .i_en_t       (i_en_t),
        .i_dec        (i_dec),
        .i_best_state (i_best_state),
        .i_last       (i_last),
        .o_bit        (o_bit),
        .o_valid      (o_valid),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // o_valid only marks a new bit when the preceding edge was enabled.
    always @(posedge clk) en_last = en;

    // Monitor: pop expected bits in order as the DUT emits them.
    always @(negedge clk) begin
        if (rst && en_last && o_valid) begin
            n_emit++;
            if (q.size() == 0) begin
                chk("spurious_valid", o_valid, 0);
            end else begin
                mon_exp = q.pop_front();
                chk("bit", o_bit, mon_exp);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0; en = 1'b1; i_en_m = 1'b0; i_en_t = 1'b0; i_last = 1'b0;
        i_dec = '0; i_best_state = '0;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_bit", o_bit, 0);
        chk("rst_done", o_done, 0);
        q.delete();
        n_emit = 0;
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_done(input int exp_bits);
        for (int k = 0; k < 100 && !o_done; k++) tick();
        chk("done", o_done, 1);
        chk("emitted", n_emit, exp_bits);
        chk("sb_empty", q.size(), 0);
    endtask

    // mode 0: random data, 1: all zero, 2: golden pattern; tail zeros follow.
    task automatic run_frame(input int n, input int tail, input int mode,
                             input int stall_at, input int freeze_at, input bit wdone);
        logic [M-1:0]  st, nst;
        logic [NS-1:0] dec;
        logic          v0;
        bit            u;
        st = '0;
        for (int t = 0; t < n + tail; t++) begin
            if (t >= n)         u = 1'b0;
            else if (mode == 0) u = 1'($urandom_range(0, 1));
            else if (mode == 1) u = 1'b0;
            else                u = gold[t % 8];
            nst = {u, st[M-1:1]};
            dec = (mode == 1) ? '0 : NS'($urandom);
            dec[nst] = st[0];
            q.push_back(u);
            i_dec = dec; i_best_state = st; i_en_m = 1'b1; i_en_t = 1'b1;
            i_last = (t == n + tail - 1);
            if (t == stall_at) begin
                i_en_t = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk("stall_valid", o_valid, 0);
                end
                i_en_t = 1'b1;
            end
            if (t == freeze_at) begin
                v0 = o_valid;
                en = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("freeze_hold", o_valid, v0);
                end
                en = 1'b1;
            end
            tick();
            if (n + tail > TBL && t == TBL - 1) chk("valid_before_run", o_valid, 0);
            if (n + tail > TBL && t == TBL)     chk("valid_rise", o_valid, 1);
            st = nst;
        end
        i_en_m = 1'b0; i_en_t = 1'b0; i_last = 1'b0;
        if (wdone) wait_done(n + tail);
    endtask

    initial begin
        do_reset();

        // Reset mid-stream, then 15 writes: still filling, nothing emitted.
        for (int t = 0; t < 8; t++) begin
            i_dec = NS'($urandom); i_en_m = 1'b1; i_en_t = 1'b1;
            tick();
        end
        do_reset();
        for (int t = 0; t < 15; t++) begin
            i_dec = NS'($urandom); i_en_m = 1'b1; i_en_t = 1'b1;
            tick();
            chk("fill_valid", o_valid, 0);
            chk("fill_bit", o_bit, 0);
            chk("fill_done", o_done, 0);
        end

        // All-zero frame of 40 columns.
        do_reset();
        run_frame(38, 2, 1, -1, -1, 1'b1);

        // Golden pattern, 32 columns plus zero tail.
        do_reset();
        run_frame(32, 2, 2, -1, -1, 1'b1);

        // Stall and freeze mid-run.
        do_reset();
        run_frame(30, 2, 0, 20, 25, 1'b1);

        // i_last on the 20th write.
        do_reset();
        run_frame(18, 2, 0, -1, -1, 1'b1);

        // Short frame: i_last on the 5th write.
        do_reset();
        run_frame(3, 2, 0, -1, -1, 1'b1);

        // i_last with an empty buffer.
        do_reset();
        i_last = 1'b1;
        tick();
        i_last = 1'b0;
        wait_done(0);

        // Reset after done clears o_done without a clock edge.
        do_reset();

        // Async reset mid-flush.
        run_frame(18, 2, 0, -1, -1, 1'b0);
        for (int k = 0; k < 3; k++) tick();
        chk("flush_valid", o_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_valid", o_valid, 0);
        chk("async_done", o_done, 0);
        q.delete();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_valid", o_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
